// File: rtl/mem_bus_unit_if.sv
// Memory-side bus between mem_bus_unit (master) and the external word-wide memory (slave).
interface mem_bus_unit_if #(
    parameter int unsigned WORD_SIZE     = 16,
    parameter int unsigned MEM_ADDR_SIZE = 6
);
    logic                     bus_req;
    logic                     bus_we;
    logic [MEM_ADDR_SIZE-1:0] bus_addr;
    logic [WORD_SIZE-1:0]     bus_wdata;
    logic [WORD_SIZE-1:0]     bus_rdata;
    logic                     bus_ack;

    modport master (
        output bus_req,
        output bus_we,
        output bus_addr,
        output bus_wdata,
        input  bus_rdata,
        input  bus_ack
    );

    modport slave (
        input  bus_req,
        input  bus_we,
        input  bus_addr,
        input  bus_wdata,
        output bus_rdata,
        output bus_ack
    );
endinterface

// File: rtl/mem_bus_unit.sv
// Registered memory-access stage: latches address/data, runs a req/ack handshake, returns read data.
// Optional ack timeout is built when MEM_TIMEOUT_EN is defined.
module mem_bus_unit #(
    parameter int unsigned WORD_SIZE      = 16,
    parameter int unsigned MEM_ADDR_SIZE  = 6,
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic                     i_mem_read,
    input  logic                     i_mem_write,
    input  logic [1:0]               i_mem_addr_select_control,
    input  logic [1:0]               i_mem_data_select_control,
    input  logic [MEM_ADDR_SIZE-1:0] i_pc,
    input  logic [MEM_ADDR_SIZE-1:0] i_ir_addr,
    input  logic [WORD_SIZE-1:0]     i_acc,
    input  logic [WORD_SIZE-1:0]     i_alu1,
    input  logic [WORD_SIZE-1:0]     i_alu2,
    mem_bus_unit_if.master           mem_bus,
    output logic [WORD_SIZE-1:0]     o_read_data,
    output logic                     o_read_valid,
    output logic                     o_busy,
    output logic                     o_error
);

    typedef enum logic [0:0] {StIdle, StAccess} state_e;

    state_e                   r_state;
    logic                     r_bus_req;
    logic                     r_bus_we;
    logic [MEM_ADDR_SIZE-1:0] r_bus_addr;
    logic [WORD_SIZE-1:0]     r_bus_wdata;
    logic [WORD_SIZE-1:0]     r_read_data;
    logic                     r_read_valid;
    logic                     r_busy;
    logic                     r_error;

    logic [MEM_ADDR_SIZE-1:0] w_addr_mux;
    logic [WORD_SIZE-1:0]     w_wdata_mux;
    logic                     w_strobe;

`ifdef MEM_TIMEOUT_EN
    logic [7:0] r_timeout_cnt;
    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);
`else
    logic [7:0] w_timeout_unused;
    assign w_timeout_unused = 8'(TIMEOUT_CYCLES);
`endif

    assign w_strobe = i_mem_read | i_mem_write;

    always_comb begin
        w_addr_mux = '0;
        unique case (i_mem_addr_select_control)
            2'b00:   w_addr_mux = '0;
            2'b01:   w_addr_mux = i_ir_addr;
            2'b10:   w_addr_mux = i_pc;
            default: w_addr_mux = i_acc[MEM_ADDR_SIZE-1:0];
        endcase
    end

    always_comb begin
        w_wdata_mux = '0;
        unique case (i_mem_data_select_control)
            2'b00:   w_wdata_mux = '0;
            2'b01:   w_wdata_mux = i_acc;
            2'b10:   w_wdata_mux = i_alu1;
            default: w_wdata_mux = i_alu2;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state      <= StIdle;
            r_bus_req    <= 1'b0;
            r_bus_we     <= 1'b0;
            r_bus_addr   <= '0;
            r_bus_wdata  <= '0;
            r_read_data  <= '0;
            r_read_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_error      <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            r_timeout_cnt <= '0;
`endif
        end else begin
            r_read_valid <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (w_strobe) begin
                        // Write wins over a simultaneous read; the collision is flagged.
                        r_bus_addr  <= w_addr_mux;
                        r_bus_wdata <= i_mem_write ? w_wdata_mux : '0;
                        r_bus_we    <= i_mem_write;
                        r_bus_req   <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= StAccess;
                        if (i_mem_read && i_mem_write) begin
                            r_error <= 1'b1;
                        end
`ifdef MEM_TIMEOUT_EN
                        r_timeout_cnt <= '0;
`endif
                    end
                end
                StAccess: begin
                    if (w_strobe) begin
                        r_error <= 1'b1;
                    end
                    if (mem_bus.bus_ack) begin
                        if (!r_bus_we) begin
                            r_read_data  <= mem_bus.bus_rdata;
                            r_read_valid <= 1'b1;
                        end
                        r_bus_req <= 1'b0;
                        r_bus_we  <= 1'b0;
                        r_busy    <= 1'b0;
                        r_state   <= StIdle;
                    end
`ifdef MEM_TIMEOUT_EN
                    else if (r_timeout_cnt == TimeoutLast) begin
                        if (!r_bus_we) begin
                            r_read_data  <= '1;
                            r_read_valid <= 1'b1;
                        end
                        r_bus_req <= 1'b0;
                        r_bus_we  <= 1'b0;
                        r_busy    <= 1'b0;
                        r_error   <= 1'b1;
                        r_state   <= StIdle;
                    end else begin
                        r_timeout_cnt <= r_timeout_cnt + 8'd1;
                    end
`endif
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign mem_bus.bus_req   = r_bus_req;
    assign mem_bus.bus_we    = r_bus_we;
    assign mem_bus.bus_addr  = r_bus_addr;
    assign mem_bus.bus_wdata = r_bus_wdata;
    assign o_read_data       = r_read_data;
    assign o_read_valid      = r_read_valid;
    assign o_busy            = r_busy;
    assign o_error           = r_error;

endmodule

// File: tb/tb_mem_bus_unit.sv
// Directed self-checking bench for mem_bus_unit; timeout scenario runs only with MEM_TIMEOUT_EN.
module tb_mem_bus_unit;

    localparam int unsigned WordSize = 16;
    localparam int unsigned AddrSize = 6;
`ifdef MEM_TIMEOUT_EN
    localparam int unsigned TimeoutCycles = 4;
`else
    localparam int unsigned TimeoutCycles = 15;
`endif

    logic                clock;
    logic                reset;
    logic                mem_read;
    logic                mem_write;
    logic [1:0]          addr_sel;
    logic [1:0]          data_sel;
    logic [AddrSize-1:0] pc;
    logic [AddrSize-1:0] ir_addr;
    logic [WordSize-1:0] acc;
    logic [WordSize-1:0] alu1;
    logic [WordSize-1:0] alu2;
    logic [WordSize-1:0] read_data;
    logic                read_valid;
    logic                busy;
    logic                error;

    int checks = 0;
    int errors = 0;

    mem_bus_unit_if #(.WORD_SIZE(WordSize), .MEM_ADDR_SIZE(AddrSize)) bus_if ();

    mem_bus_unit #(
        .WORD_SIZE     (WordSize),
        .MEM_ADDR_SIZE (AddrSize),
        .TIMEOUT_CYCLES(TimeoutCycles)
    ) dut (
        .i_clock                  (clock),
        .i_reset                  (reset),
        .i_mem_read               (mem_read),
        .i_mem_write              (mem_write),
        .i_mem_addr_select_control(addr_sel),
        .i_mem_data_select_control(data_sel),
        .i_pc                     (pc),
        .i_ir_addr                (ir_addr),
        .i_acc                    (acc),
        .i_alu1                   (alu1),
        .i_alu2                   (alu2),
        .mem_bus                  (bus_if),
        .o_read_data              (read_data),
        .o_read_valid             (read_valid),
        .o_busy                   (busy),
        .o_error                  (error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance past one rising edge; outputs are sampled and inputs changed 1 ns later.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if (bus_if.bus_req !== 1'b0) begin
            errors++; $display("FAIL rst_req got=%0h exp=0", bus_if.bus_req);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL rst_busy got=%0h exp=0", busy);
        end
        checks++;
        if (error !== 1'b0) begin
            errors++; $display("FAIL rst_error got=%0h exp=0", error);
        end
        checks++;
        if (read_data !== 16'h0000 || read_valid !== 1'b0) begin
            errors++; $display("FAIL rst_rdata got=%0h/%0h exp=0/0", read_data, read_valid);
        end
        reset = 1'b0;
    endtask

    task automatic test_zero_wait_read();
        bus_if.bus_ack   = 1'b1;
        bus_if.bus_rdata = 16'hBEEF;
        addr_sel = 2'b10;
        pc       = 6'h05;
        data_sel = 2'b01;
        acc      = 16'hFFFF;
        mem_read = 1'b1;
        tick();
        mem_read = 1'b0;
        checks++;
        if (bus_if.bus_req !== 1'b1 || bus_if.bus_addr !== 6'h05 || bus_if.bus_we !== 1'b0) begin
            errors++;
            $display("FAIL zw_req got req=%0h addr=%0h we=%0h exp 1/05/0",
                     bus_if.bus_req, bus_if.bus_addr, bus_if.bus_we);
        end
        checks++;
        if (bus_if.bus_wdata !== 16'h0000 || busy !== 1'b1 || read_valid !== 1'b0) begin
            errors++;
            $display("FAIL zw_wdata got wdata=%0h busy=%0h rv=%0h exp 0/1/0",
                     bus_if.bus_wdata, busy, read_valid);
        end
        tick();
        checks++;
        if (read_data !== 16'hBEEF || read_valid !== 1'b1) begin
            errors++; $display("FAIL zw_data got=%0h/%0h exp=BEEF/1", read_data, read_valid);
        end
        checks++;
        if (bus_if.bus_req !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL zw_done got req=%0h busy=%0h exp 0/0", bus_if.bus_req, busy);
        end
        bus_if.bus_ack = 1'b0;
        tick();
        checks++;
        if (read_valid !== 1'b0 || error !== 1'b0 || read_data !== 16'hBEEF) begin
            errors++;
            $display("FAIL zw_pulse got rv=%0h err=%0h rdata=%0h exp 0/0/BEEF",
                     read_valid, error, read_data);
        end
    endtask

    task automatic test_wait_write();
        data_sel  = 2'b10;
        alu1      = 16'h1234;
        addr_sel  = 2'b01;
        ir_addr   = 6'h2A;
        mem_write = 1'b1;
        tick();
        mem_write = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus_if.bus_req !== 1'b1 || bus_if.bus_we !== 1'b1 ||
                bus_if.bus_wdata !== 16'h1234 || bus_if.bus_addr !== 6'h2A) begin
                errors++;
                $display("FAIL ww_hold[%0d] got req=%0h we=%0h wdata=%0h addr=%0h exp 1/1/1234/2A",
                         i, bus_if.bus_req, bus_if.bus_we, bus_if.bus_wdata, bus_if.bus_addr);
            end
            if (i < 3) tick();
        end
        bus_if.bus_ack   = 1'b1;
        bus_if.bus_rdata = 16'h7777;
        tick();
        bus_if.bus_ack = 1'b0;
        checks++;
        if (busy !== 1'b0 || bus_if.bus_req !== 1'b0 || bus_if.bus_we !== 1'b0) begin
            errors++;
            $display("FAIL ww_done got busy=%0h req=%0h we=%0h exp 0/0/0",
                     busy, bus_if.bus_req, bus_if.bus_we);
        end
        checks++;
        if (read_valid !== 1'b0 || read_data !== 16'hBEEF || error !== 1'b0) begin
            errors++;
            $display("FAIL ww_nord got rv=%0h rdata=%0h err=%0h exp 0/BEEF/0",
                     read_valid, read_data, error);
        end
    endtask

    task automatic test_back_to_back();
        bus_if.bus_ack   = 1'b1;
        bus_if.bus_rdata = 16'h0F0F;
        addr_sel = 2'b10;
        pc       = 6'h11;
        mem_read = 1'b1;
        tick();
        mem_read = 1'b0;
        checks++;
        if (bus_if.bus_req !== 1'b1 || bus_if.bus_addr !== 6'h11) begin
            errors++;
            $display("FAIL b2b_rd got req=%0h addr=%0h exp 1/11", bus_if.bus_req, bus_if.bus_addr);
        end
        tick();
        checks++;
        if (read_valid !== 1'b1 || read_data !== 16'h0F0F || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_rdone got rv=%0h rdata=%0h busy=%0h exp 1/0F0F/0",
                     read_valid, read_data, busy);
        end
        data_sel  = 2'b11;
        alu2      = 16'hCAFE;
        addr_sel  = 2'b00;
        bus_if.bus_rdata = 16'h1111;
        mem_write = 1'b1;
        tick();
        mem_write = 1'b0;
        checks++;
        if (bus_if.bus_req !== 1'b1 || bus_if.bus_we !== 1'b1 || bus_if.bus_addr !== 6'h00 ||
            bus_if.bus_wdata !== 16'hCAFE || read_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_wr got req=%0h we=%0h addr=%0h wdata=%0h rv=%0h exp 1/1/00/CAFE/0",
                     bus_if.bus_req, bus_if.bus_we, bus_if.bus_addr, bus_if.bus_wdata, read_valid);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || read_valid !== 1'b0 || read_data !== 16'h0F0F || error !== 1'b0) begin
            errors++;
            $display("FAIL b2b_wdone got busy=%0h rv=%0h rdata=%0h err=%0h exp 0/0/0F0F/0",
                     busy, read_valid, read_data, error);
        end
        bus_if.bus_ack = 1'b0;
    endtask

    task automatic test_overrun();
        addr_sel = 2'b11;
        acc      = 16'h0007;
        mem_read = 1'b1;
        tick();
        addr_sel = 2'b10;
        pc       = 6'h3F;
        tick();
        mem_read = 1'b0;
        checks++;
        if (error !== 1'b1) begin
            errors++; $display("FAIL ovr_err got=%0h exp=1", error);
        end
        checks++;
        if (bus_if.bus_addr !== 6'h07 || bus_if.bus_we !== 1'b0 || bus_if.bus_req !== 1'b1) begin
            errors++;
            $display("FAIL ovr_hold got addr=%0h we=%0h req=%0h exp 07/0/1",
                     bus_if.bus_addr, bus_if.bus_we, bus_if.bus_req);
        end
        bus_if.bus_ack   = 1'b1;
        bus_if.bus_rdata = 16'h5555;
        tick();
        bus_if.bus_ack = 1'b0;
        checks++;
        if (read_data !== 16'h5555 || read_valid !== 1'b1 || error !== 1'b1) begin
            errors++;
            $display("FAIL ovr_done got rdata=%0h rv=%0h err=%0h exp 5555/1/1",
                     read_data, read_valid, error);
        end
        tick();
        tick();
        checks++;
        if (error !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL ovr_sticky got err=%0h busy=%0h exp 1/0", error, busy);
        end
    endtask

    task automatic test_simultaneous();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (error !== 1'b0) begin
            errors++; $display("FAIL sim_clr got=%0h exp=0", error);
        end
        addr_sel  = 2'b11;
        data_sel  = 2'b01;
        acc       = 16'h0013;
        mem_read  = 1'b1;
        mem_write = 1'b1;
        tick();
        mem_read  = 1'b0;
        mem_write = 1'b0;
        checks++;
        if (bus_if.bus_we !== 1'b1 || bus_if.bus_addr !== 6'h13 ||
            bus_if.bus_wdata !== 16'h0013 || error !== 1'b1) begin
            errors++;
            $display("FAIL sim_wr got we=%0h addr=%0h wdata=%0h err=%0h exp 1/13/0013/1",
                     bus_if.bus_we, bus_if.bus_addr, bus_if.bus_wdata, error);
        end
        bus_if.bus_ack   = 1'b1;
        bus_if.bus_rdata = 16'hAAAA;
        tick();
        bus_if.bus_ack = 1'b0;
        checks++;
        if (read_valid !== 1'b0 || read_data !== 16'h0000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL sim_done got rv=%0h rdata=%0h busy=%0h exp 0/0000/0",
                     read_valid, read_data, busy);
        end
    endtask

    task automatic test_reset_mid_access();
        addr_sel = 2'b01;
        ir_addr  = 6'h09;
        mem_read = 1'b1;
        tick();
        tick();
        mem_read = 1'b0;
        checks++;
        if (bus_if.bus_req !== 1'b1 || error !== 1'b1) begin
            errors++;
            $display("FAIL rma_pre got req=%0h err=%0h exp 1/1", bus_if.bus_req, error);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (bus_if.bus_req !== 1'b0 || busy !== 1'b0 || error !== 1'b0 || read_valid !== 1'b0) begin
            errors++;
            $display("FAIL rma_post got req=%0h busy=%0h err=%0h rv=%0h exp 0/0/0/0",
                     bus_if.bus_req, busy, error, read_valid);
        end
    endtask

`ifdef MEM_TIMEOUT_EN
    task automatic test_timeout();
        bus_if.bus_ack = 1'b0;
        addr_sel = 2'b10;
        pc       = 6'h22;
        mem_read = 1'b1;
        tick();
        mem_read = 1'b0;
        for (int i = 1; i < 4; i++) begin
            tick();
            checks++;
            if (bus_if.bus_req !== 1'b1 || read_valid !== 1'b0) begin
                errors++;
                $display("FAIL to_wait[%0d] got req=%0h rv=%0h exp 1/0", i, bus_if.bus_req, read_valid);
            end
        end
        tick();
        checks++;
        if (bus_if.bus_req !== 1'b0 || busy !== 1'b0 || read_data !== 16'hFFFF ||
            read_valid !== 1'b1 || error !== 1'b1) begin
            errors++;
            $display("FAIL to_abort got req=%0h busy=%0h rdata=%0h rv=%0h err=%0h exp 0/0/FFFF/1/1",
                     bus_if.bus_req, busy, read_data, read_valid, error);
        end
        tick();
        checks++;
        if (read_valid !== 1'b0) begin
            errors++; $display("FAIL to_pulse got=%0h exp=0", read_valid);
        end
    endtask
`endif

    initial begin
        reset            = 1'b1;
        mem_read         = 1'b0;
        mem_write        = 1'b0;
        addr_sel         = 2'b00;
        data_sel         = 2'b00;
        pc               = '0;
        ir_addr          = '0;
        acc              = '0;
        alu1             = '0;
        alu2             = '0;
        bus_if.bus_ack   = 1'b0;
        bus_if.bus_rdata = '0;

        test_reset();
        test_zero_wait_read();
        test_wait_write();
        test_back_to_back();
        test_overrun();
        test_simultaneous();
        test_reset_mid_access();
`ifdef MEM_TIMEOUT_EN
        test_timeout();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_bus_unit.md
# mem_bus_unit

Registered memory-access stage between the CPU controller's memory strobes and the external word-wide memory. Selects the access address and the write data from the datapath, holds them stable through a `bus_req`/`bus_ack` handshake, and returns captured read data with a one-cycle valid strobe. It also reports `busy` back to the sequencer and raises a sticky `error` on protocol misuse or timeout.

## Interface

Parameters:
- `WORD_SIZE`, 16, data word width.
- `MEM_ADDR_SIZE`, 6, address width.
- `TIMEOUT_CYCLES`, 15, maximum wait for `bus_ack` in ACCESS. Used only with `MEM_TIMEOUT_EN`. Range 1..255.

Ports:
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `mem_read`  in  1  read request strobe.
- `mem_write`  in  1  write request strobe.
- `mem_addr_select_control`  in  2  address source: 00 zero, 01 `ir_addr`, 10 `pc`, 11 `acc[MEM_ADDR_SIZE-1:0]`.
- `mem_data_select_control`  in  2  write data source: 00 zero, 01 `acc`, 10 `alu1`, 11 `alu2`.
- `pc`  in  MEM_ADDR_SIZE  program counter.
- `ir_addr`  in  MEM_ADDR_SIZE  instruction address field.
- `acc`, `alu1`, `alu2`  in  WORD_SIZE each  datapath registers.
- `bus_req`  out  1  access in progress.
- `bus_we`  out  1  1 = write.
- `bus_addr`  out  MEM_ADDR_SIZE  latched address.
- `bus_wdata`  out  WORD_SIZE  latched write data.
- `bus_rdata`  in  WORD_SIZE  memory read data, valid with `bus_ack`.
- `bus_ack`  in  1  access complete.
- `read_data`  out  WORD_SIZE  last captured read word.
- `read_valid`  out  1  one-cycle pulse when `read_data` has been updated.
- `busy`  out  1  unit is not in IDLE.
- `error`  out  1  sticky fault flag, cleared only by `reset`.

## Operation

The unit has two states, IDLE and ACCESS. The state register and all outputs are registered.

- **Reset:** state = IDLE. All outputs = 0, including `read_data`. The timeout counter = 0.

**IDLE**
- If `mem_write`=1 or `mem_read`=1 at a rising edge, latch `bus_addr` and `bus_wdata` from the select muxes.
- At the same edge, set `bus_we` = `mem_write`, set `bus_req`=1 and `busy`=1, and go to ACCESS.
- If `mem_read` and `mem_write` are both 1, perform the write, ignore the read, and set `error`.
- For a read, `bus_wdata` is latched as 0.

**ACCESS**
- `bus_req`, `bus_we`, `bus_addr` and `bus_wdata` stay constant.
- `mem_read` or `mem_write` sampled high here sets `error`. The request is dropped, not queued.
- On the edge where `bus_ack`=1:
  - For a read, capture `bus_rdata` into `read_data` and pulse `read_valid`.
  - For a write, leave `read_data` unchanged and do not pulse `read_valid`.
  - Clear `bus_req`, `bus_we` and `busy`, and return to IDLE.
- `bus_ack` while in IDLE is ignored and does not set `error`.

**Reset mid-access:** takes effect at the next edge regardless of state. `bus_req` drops immediately, with no completion.

## Timing

- Request sampled at edge 0: `bus_req`, `bus_addr`, `bus_we` and `busy` are valid from edge 0 until the completing edge.
- `bus_ack` sampled high at edge k (k ≥ 1): `read_data`/`read_valid` are valid after edge k, and `read_valid` is low again after edge k+1.
- Zero-wait memory (ack tied high): request to `read_valid` takes 1 cycle, and a new request may be accepted at edge k+1.
- Minimum back-to-back throughput is one access per 2 cycles.
- The sequencer must hold off new strobes while `busy`=1. Otherwise the strobe is dropped and `error` is set.

## Configuration

- **`MEM_TIMEOUT_EN` defined:**
  - An 8-bit counter clears on entry to ACCESS and increments each cycle in ACCESS without `bus_ack`.
  - When it reaches `TIMEOUT_CYCLES`, the unit aborts: `bus_req` and `busy` drop, state returns to IDLE, and `error` is set.
  - For an aborted read, `read_data` = all ones and `read_valid` pulses once.
  - `bus_ack` arriving at the same edge as the timeout wins: the access completes normally and `error` is not set.
- **Not defined:** no counter is built, ACCESS waits indefinitely, and `TIMEOUT_CYCLES` is unused.

## Test plan

- **Zero-wait read:** apply `reset`, then `mem_read`=1 with addr_sel=10, `pc`=6'h05, `bus_ack`=1, `bus_rdata`=16'hBEEF. Required: `bus_addr`=05 and `bus_we`=0 one cycle; next cycle `read_data`=BEEF and `read_valid`=1 for exactly one cycle.
- **Wait-state write:** `mem_write`=1, data_sel=10, `alu1`=16'h1234, addr_sel=01, `ir_addr`=6'h2A, `bus_ack` asserted after 3 cycles. Required: `bus_we`=1, `bus_wdata`=1234 and `bus_addr`=2A stable for 4 cycles; `busy` low afterwards; no `read_valid`; `error`=0.
- **Overrun:** pulse `mem_read` again while `busy`=1. Required: the second request is ignored, `error`=1 and stays 1 until `reset`.
- **Simultaneous strobes:** `mem_read`=`mem_write`=1 with acc_sel=11, `acc`=16'h0013. Required: a write to address 13 and `error`=1.
- **Timeout (`MEM_TIMEOUT_EN`, `TIMEOUT_CYCLES`=4):** a read with no ack. Required: `bus_req` falls after 4 ACCESS cycles, `read_data`=FFFF, one `read_valid` pulse, `error`=1.
- **Reset mid-access:** assert `reset` during ACCESS. Required: after the next edge `bus_req`=0, `busy`=0, `error`=0, `read_valid`=0.
